fetch_unit: RTL and testbench

Instruction fetch stage for the out-of-order core. Owns the program counter, drives the instruction ROM address, and captures the 32-bit word the ROM returns combinationally in the same cycle. Fetched instructions, each tagged with its PC, are buffered in a small FIFO and handed to decode over a valid/ready handshake. The stage halts on the all-zero end-of-trace word and restarts on a redirect from the back end.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] END_OF_TRACE = 32'h0;
  localparam int          PC_STEP      = 4;

  // Buffer entry at the default core widths (12-bit PC, 32-bit instruction).
  typedef struct packed {
    logic [11:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: circular FIFO with head/tail pointers and an occupancy count.
// Flush wins over push and pop; push is accepted when full only alongside a pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; the occupancy count qualifies every read.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, FETCH/HALT control and fetch buffer.
// Output handshake: a head entry transfers on a rising edge where out_valid && out_ready.
module fetch_unit #(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic                   halted
);

  import fetch_pkg::*;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  push;
  logic                  end_of_trace;
  entry_t                push_entry;
  entry_t                head_entry;
  logic                  unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign rom_addr     = pc_q;
  assign end_of_trace = (rom_data == INSTR_WIDTH'(END_OF_TRACE));
  assign pop          = !fifo_empty && out_ready;
  // A redirect discards this cycle's fetch, so it also blocks the push.
  assign push         = (state_q == FETCH) && !end_of_trace && (!fifo_full || pop)
                        && !redirect_valid;
  assign push_entry   = '{pc: pc_q, instr: rom_data};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid)                          state_d = FETCH;
    else if (state_q == FETCH && end_of_trace)   state_d = HALT;
  end

  always_comb begin
    halted    = (state_q == HALT);
    out_valid = !fifo_empty;
    out_instr = out_valid ? head_entry.instr : '0;
    out_pc    = out_valid ? head_entry.pc    : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              pc_q <= '0;
    else if (redirect_valid) pc_q <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    else if (push)           pc_q <= pc_q + ADDR_WIDTH'(PC_STEP);
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_WIDTH + INSTR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head_entry)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam int AW    = 12;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  localparam logic [IW-1:0] W0 = 32'h00500093;
  localparam logic [IW-1:0] W1 = 32'h00A00113;
  localparam logic [IW-1:0] W2 = 32'h002081B3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          halted;

  logic [IW-1:0] rom [1024];
  assign rom_data = rom[rom_addr[AW-1:2]];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: architectural PC, halt flag and a queue of {pc, instr}.
  logic [AW+IW-1:0] m_q[$];
  logic [AW-1:0]    m_pc;
  logic             m_halt;

  task automatic model_reset();
    m_q.delete();
    m_pc   = '0;
    m_halt = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [AW-1:0] rpc, input logic rdy);
    logic          pop;
    logic          can;
    logic [IW-1:0] w;
    if (rv) begin
      m_q.delete();
      m_pc   = rpc & 12'hFFC;
      m_halt = 1'b0;
    end else begin
      w   = rom[m_pc[AW-1:2]];
      pop = (m_q.size() != 0) && rdy;
      can = !m_halt && (w != 0) && ((m_q.size() < DEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (can) begin
        m_q.push_back({m_pc, w});
        m_pc = m_pc + 12'd4;
      end else if (!m_halt && w == 0) begin
        m_halt = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic          ev;
    logic [AW-1:0] epc;
    logic [IW-1:0] ein;
    ev  = (m_q.size() != 0);
    epc = ev ? m_q[0][AW+IW-1:IW] : '0;
    ein = ev ? m_q[0][IW-1:0] : '0;
    chk({tag, " rom_addr"}, 32'(rom_addr), 32'(m_pc));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, " out_pc"}, 32'(out_pc), 32'(epc));
    chk({tag, " out_instr"}, out_instr, ein);
    chk({tag, " halted"}, 32'(halted), 32'(m_halt));
  endtask

  task automatic cycle(input logic rv, input logic [AW-1:0] rpc, input logic rdy, input string tag);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(rv, rpc, rdy);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(1'b0, '0, 1'b0, "reset");
    rst_n = 1'b1;
  endtask

  task automatic fill_rom_nonzero();
    for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 | 32'(i);
  endtask

  typedef struct {
    logic          rv;
    logic [AW-1:0] rpc;
    logic          rdy;
    logic          valid;
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic [AW-1:0] addr;
    logic          halted;
  } vec_t;

  vec_t vecs[13];

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    model_reset();

    // Straight-line program, halt, redirect out of HALT, and drain while halted.
    vecs[0]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h000, W0,    12'h004, 1'b0};
    vecs[1]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h004, W1,    12'h008, 1'b0};
    vecs[2]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h008, W2,    12'h00C, 1'b0};
    vecs[3]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 32'h0, 12'h00C, 1'b1};
    vecs[4]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 32'h0, 12'h00C, 1'b1};
    vecs[5]  = '{1'b1, 12'h004, 1'b1, 1'b0, 12'h000, 32'h0, 12'h004, 1'b0};
    vecs[6]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h004, W1,    12'h008, 1'b0};
    vecs[7]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h008, W2,    12'h00C, 1'b0};
    vecs[8]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 32'h0, 12'h00C, 1'b1};
    vecs[9]  = '{1'b1, 12'h00A, 1'b0, 1'b0, 12'h000, 32'h0, 12'h008, 1'b0};
    vecs[10] = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h008, W2,    12'h00C, 1'b0};
    vecs[11] = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h008, W2,    12'h00C, 1'b1};
    vecs[12] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 32'h0, 12'h00C, 1'b1};

    rom[0] = W0;
    rom[1] = W1;
    rom[2] = W2;
    rom[3] = 32'h0;

    do_reset();
    chk("reset rom_addr", 32'(rom_addr), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset halted", 32'(halted), 32'h0);
    chk("reset out_instr", out_instr, 32'h0);
    chk("reset out_pc", 32'(out_pc), 32'h0);

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].rv, vecs[i].rpc, vecs[i].rdy, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d out_pc", i), 32'(out_pc), 32'(vecs[i].pc));
      chk($sformatf("vec%0d out_instr", i), out_instr, vecs[i].instr);
      chk($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d halted", i), 32'(halted), 32'(vecs[i].halted));
    end

    // Backpressure: buffer fills to DEPTH and the PC stalls, then drains in order.
    fill_rom_nonzero();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, "bp_fill");
    chk("bp stall rom_addr", 32'(rom_addr), 32'h010);
    chk("bp head pc", 32'(out_pc), 32'h000);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("bp drain%0d out_pc", j), 32'(out_pc), 32'(4 * j));
      chk($sformatf("bp drain%0d out_valid", j), 32'(out_valid), 32'h1);
      cycle(1'b0, '0, 1'b1, "bp_drain");
    end

    // Redirect with three entries buffered; low address bits are dropped.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, "rd_fill");
    cycle(1'b1, 12'h022, 1'b1, "rd_flush");
    chk("rd out_valid", 32'(out_valid), 32'h0);
    chk("rd rom_addr", 32'(rom_addr), 32'h020);
    cycle(1'b0, '0, 1'b1, "rd_first");
    chk("rd first out_pc", 32'(out_pc), 32'h020);
    chk("rd first out_valid", 32'(out_valid), 32'h1);

    // PC wrap from 0xFFC to 0x000.
    rom[1] = 32'h0;
    cycle(1'b1, 12'hFFC, 1'b1, "wrap_redirect");
    cycle(1'b0, '0, 1'b1, "wrap_a");
    chk("wrap out_pc first", 32'(out_pc), 32'hFFC);
    cycle(1'b0, '0, 1'b1, "wrap_b");
    chk("wrap out_pc second", 32'(out_pc), 32'h000);
    chk("wrap out_instr second", out_instr, 32'h1000_0000);

    // Reset with a full buffer and a simultaneous redirect.
    fill_rom_nonzero();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, "rst_fill");
    rst_n = 1'b0;
    cycle(1'b1, 12'h100, 1'b1, "rst_mid");
    rst_n = 1'b1;
    chk("rst_mid rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_mid out_valid", 32'(out_valid), 32'h0);
    chk("rst_mid halted", 32'(halted), 32'h0);
    chk("rst_mid out_instr", out_instr, 32'h0);
    chk("rst_mid out_pc", 32'(out_pc), 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom() | 32'h1);
    for (int n = 0; n < 2000; n++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      cycle(($urandom_range(0, 19) == 0), AW'($urandom()), ($urandom_range(0, 3) != 0), "rand");
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
